from_boot_loader: RTL and testbench

Wishbone master that sits directly upstream of the FROM controller on the monitor's internal bus. After reset, or on request, it reads a configuration image out of the FROM byte by byte, validates a magic header and optional checksum, and streams the payload bytes to the downstream configuration register file. It reports busy, done and error status to the system controller.

---
 rtl/from_boot_loader_if.sv | 21 ++
 rtl/from_boot_loader.sv | 194 +++++++++++++++++++
 tb/tb_from_boot_loader.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/from_boot_loader_if.sv
// Wishbone read-master bundle between the boot loader and the FROM controller.
// dat_w carries master write data, dat_r carries slave read data.
interface from_boot_loader_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [15:0] adr;
  logic [15:0] dat_w;
  logic [15:0] dat_r;
  logic        ack;

  modport master (
    output cyc, stb, we, adr, dat_w,
    input  dat_r, ack
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w,
    output dat_r, ack
  );
endinterface

// File: rtl/from_boot_loader.sv
// FROM boot loader: reads a configuration image byte by byte over Wishbone,
// checks the magic header (and optionally a trailing checksum byte) and streams
// payload bytes to the configuration register file.
// Optional feature: define FROM_LOADER_CHECKSUM_EN to treat the last image byte
// as a checksum (sum of all bytes mod 256 must be zero).
module from_boot_loader #(
  parameter int unsigned NUM_BYTES = 128,
  parameter logic [7:0]  MAGIC     = 8'hA5,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  from_boot_loader_if.master   wbm,
  input  logic                 reload_i,
  output logic                 ld_valid_o,
  output logic [6:0]           ld_addr_o,
  output logic [7:0]           ld_data_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [1:0]           err_o
);

  localparam logic [6:0] LAST_IDX = 7'(NUM_BYTES - 1);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

`ifdef FROM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_GAP,
    ST_DONE,
    ST_FAIL
  } state_t;

  state_t      state_q, state_d;
  logic        start_q;
  logic [6:0]  idx_q;
  logic [7:0]  byte_q;
  logic [7:0]  tcnt_q;
  logic        last_ok;

  logic        req_q, req_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [1:0]  err_q, err_d;
  logic        ld_valid_q, ld_valid_d;
  logic [6:0]  ld_addr_q, ld_addr_d;
  logic [7:0]  ld_data_q, ld_data_d;

`ifdef FROM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;

  // Running mod-256 sum of every byte read in the current load.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      csum_q <= '0;
    end else if (state_q == ST_IDLE && state_d == ST_REQ) begin
      csum_q <= '0;
    end else if (state_q == ST_REQ && wbm.ack) begin
      csum_q <= csum_q + wbm.dat_r[7:0];
    end
  end

  assign last_ok = (csum_q == 8'h00);
`else
  assign last_ok = 1'b1;
`endif

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_q || reload_i) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (wbm.ack)                 state_d = ST_GAP;
        else if (tcnt_q == TO_LAST)  state_d = ST_FAIL;
      end
      ST_GAP: begin
        if (idx_q == '0 && byte_q != MAGIC) state_d = ST_FAIL;
        else if (idx_q == LAST_IDX)         state_d = last_ok ? ST_DONE : ST_FAIL;
        else                                state_d = ST_REQ;
      end
      ST_DONE, ST_FAIL: begin
        if (reload_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: start flag, byte index, captured byte and ack timeout counter.
  // A reload seen in DONE/FAIL only moves to IDLE, so it is latched in the
  // start flag to launch the load from IDLE on the following edge.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      start_q <= 1'b1;
      idx_q   <= '0;
      byte_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (state_d == ST_REQ) begin
            start_q <= 1'b0;
            idx_q   <= '0;
            tcnt_q  <= '0;
          end
        end
        ST_REQ: begin
          if (wbm.ack) byte_q <= wbm.dat_r[7:0];
          else         tcnt_q <= tcnt_q + 8'd1;
        end
        ST_GAP: begin
          if (state_d == ST_REQ) begin
            idx_q  <= idx_q + 7'd1;
            tcnt_q <= '0;
          end
        end
        ST_DONE, ST_FAIL: begin
          if (reload_i) start_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output decode: next values of the registered outputs.
  always_comb begin
    req_d      = (state_d == ST_REQ);
    busy_d     = (state_d == ST_REQ) || (state_d == ST_GAP);
    ld_valid_d = (state_q == ST_GAP) && (idx_q != '0) &&
                 !(CSUM_EN && idx_q == LAST_IDX);
    ld_addr_d  = ld_valid_d ? idx_q  : ld_addr_q;
    ld_data_d  = ld_valid_d ? byte_q : ld_data_q;
    done_d     = (state_d == ST_DONE) || (done_q && state_d != ST_REQ);
    err_d      = err_q;
    if (state_q == ST_IDLE && state_d == ST_REQ) begin
      err_d = 2'b00;
    end else if (state_q == ST_REQ && state_d == ST_FAIL) begin
      err_d = 2'b11;
    end else if (state_q == ST_GAP && state_d == ST_FAIL) begin
      err_d = (idx_q == '0) ? 2'b01 : 2'b10;
    end
  end

  // Output registers; async reset drops the bus request immediately.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= '0;
      ld_valid_q <= 1'b0;
      ld_addr_q  <= '0;
      ld_data_q  <= '0;
    end else begin
      req_q      <= req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ld_valid_q <= ld_valid_d;
      ld_addr_q  <= ld_addr_d;
      ld_data_q  <= ld_data_d;
    end
  end

  assign wbm.cyc    = req_q;
  assign wbm.stb    = req_q;
  assign wbm.we     = 1'b0;
  assign wbm.adr    = {9'b0, idx_q};
  assign wbm.dat_w  = '0;
  assign ld_valid_o = ld_valid_q;
  assign ld_addr_o  = ld_addr_q;
  assign ld_data_o  = ld_data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_from_boot_loader.sv
// Randomized self-checking bench for from_boot_loader (8-byte image, TIMEOUT 16).
// Expected load-stream contents and status come from an image-level model.
module tb_from_boot_loader;

  localparam int unsigned NB = 8;
  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       reload = 1'b0;
  logic       ld_valid;
  logic [6:0] ld_addr;
  logic [7:0] ld_data;
  logic       busy;
  logic       done;
  logic [1:0] err;

  from_boot_loader_if bus ();

  from_boot_loader #(
    .NUM_BYTES (NB),
    .MAGIC     (8'hA5),
    .TIMEOUT   (TO)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wbm        (bus.master),
    .reload_i   (reload),
    .ld_valid_o (ld_valid),
    .ld_addr_o  (ld_addr),
    .ld_data_o  (ld_data),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [7:0]  mem [NB];
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  int unsigned bus_cycles = 0;
  int unsigned cyc_hi = 0;
  int unsigned run_err = 0;
  logic [15:0] first_adr = '0;
  logic        prev_v = 1'b0;
  logic        prev_cyc = 1'b0;
  bit          never_ack = 1'b0;
  int unsigned stb_cnt = 0;
  int unsigned lat = 4;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // FROM slave: acks after 4..7 cycles of strobe, garbage in the upper data byte.
  initial begin
    bus.ack   = 1'b0;
    bus.dat_r = '0;
  end

  always @(negedge clk) begin
    if (bus.cyc && bus.stb && !never_ack && !bus.ack) begin
      stb_cnt++;
      if (stb_cnt >= lat) begin
        bus.ack   = 1'b1;
        bus.dat_r = {8'($urandom), mem[bus.adr[2:0]]};
      end
    end else begin
      bus.ack   = 1'b0;
      bus.dat_r = 16'($urandom);
      stb_cnt   = 0;
      lat       = $urandom_range(4, 7);
    end
  end

  // Load-stream and bus-cycle monitor.
  always @(negedge clk) begin
    if (ld_valid) got_q.push_back({1'b0, ld_addr, ld_data});
    if (ld_valid && prev_v) run_err++;
    prev_v = ld_valid;
    if (bus.cyc && !prev_cyc) begin
      if (bus_cycles == 0) first_adr = bus.adr;
      bus_cycles++;
    end
    if (bus.cyc) cyc_hi++;
    prev_cyc = bus.cyc;
  end

  task automatic clear_capture();
    got_q.delete();
    bus_cycles = 0;
    cyc_hi     = 0;
    run_err    = 0;
    first_adr  = '1;
  endtask

  // Image-level model of the expected load outcome.
  task automatic model(output logic e_done, output logic [1:0] e_err, output int unsigned e_cyc);
    logic [7:0]  sum;
    int unsigned last;
    exp_q.delete();
    if (mem[0] != 8'hA5) begin
      e_done = 1'b0;
      e_err  = 2'd1;
      e_cyc  = 1;
      return;
    end
    sum = '0;
    for (int i = 0; i < NB; i++) sum += mem[i];
    e_cyc = NB;
`ifdef FROM_LOADER_CHECKSUM_EN
    last   = NB - 2;
    e_done = (sum == 8'h00);
    e_err  = (sum == 8'h00) ? 2'd0 : 2'd2;
`else
    last   = NB - 1;
    e_done = 1'b1;
    e_err  = 2'd0;
`endif
    for (int i = 1; i <= int'(last); i++) exp_q.push_back({1'b0, 7'(i), mem[i]});
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic wait_load(input string tag);
    int unsigned n;
    n = 0;
    while (!busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    check({tag, "_status_cleared"}, {29'd0, done, err}, 32'd0);
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic compare_result(input string tag);
    logic        e_done;
    logic [1:0]  e_err;
    int unsigned e_cyc;
    int unsigned n;
    model(e_done, e_err, e_cyc);
    check({tag, "_nstrobes"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < int'(n); i++) check({tag, "_strobe"}, 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, "_done"}, 32'(done), 32'(e_done));
    check({tag, "_err"}, 32'(err), 32'(e_err));
    check({tag, "_bus_cycles"}, bus_cycles, e_cyc);
    check({tag, "_strobe_width"}, run_err, 0);
  endtask

  task automatic good_image();
    logic [7:0] sum;
    sum = 8'hA5;
    mem[0] = 8'hA5;
    for (int i = 1; i < NB - 1; i++) begin
      mem[i] = 8'($urandom);
      sum += mem[i];
    end
    mem[NB-1] = 8'h00 - sum;
  endtask

  initial begin
    int unsigned n;
    // Reset state.
    mem[0] = 8'hA5;
    for (int i = 1; i < NB - 1; i++) mem[i] = 8'(i);
    mem[NB-1] = 8'h00 - 8'hBA;
    repeat (3) @(negedge clk);
    check("rst_cyc", 32'(bus.cyc), 0);
    check("rst_stb", 32'(bus.stb), 0);
    check("rst_we", 32'(bus.we), 0);
    check("rst_adr", 32'(bus.adr), 0);
    check("rst_dat_w", 32'(bus.dat_w), 0);
    check("rst_ld", {15'd0, ld_valid, ld_addr, ld_data}, 0);
    check("rst_status", {28'd0, busy, done, err}, 0);

    // Automatic load after reset release: A5,01..06,checksum.
    clear_capture();
    rst_n = 1'b1;
    wait_load("boot");
    compare_result("boot");
    check("boot_first_adr", 32'(first_adr), 0);

    // Bad magic.
    mem[0] = 8'h5A;
    clear_capture();
    pulse_reload();
    wait_load("magic");
    compare_result("magic");

    // Good image with byte 3 corrupted.
    mem[0] = 8'hA5;
    for (int i = 1; i < NB - 1; i++) mem[i] = 8'(i);
    mem[NB-1] = 8'h46;
    mem[3] = mem[3] ^ 8'h10;
    clear_capture();
    pulse_reload();
    wait_load("corrupt");
    compare_result("corrupt");

    // Randomized images.
    for (int t = 0; t < 8; t++) begin
      good_image();
      if ($urandom_range(0, 3) == 0) mem[0] = 8'($urandom_range(0, 255)) ^ 8'h01;
      if ($urandom_range(0, 2) == 0) mem[$urandom_range(1, NB-1)] ^= 8'($urandom_range(1, 255));
      clear_capture();
      pulse_reload();
      wait_load("rand");
      compare_result("rand");
    end

    // Ack timeout.
    never_ack = 1'b1;
    clear_capture();
    pulse_reload();
    wait_load("timeout");
    check("timeout_cyc_cycles", cyc_hi, TO);
    check("timeout_err", 32'(err), 3);
    check("timeout_done", 32'(done), 0);
    check("timeout_cyc_low", 32'(bus.cyc), 0);
    check("timeout_nstrobes", got_q.size(), 0);
    never_ack = 1'b0;

    // Reload pulsed mid-load is ignored; reload from FAIL/DONE clears done.
    good_image();
    clear_capture();
    pulse_reload();
    repeat (12) @(negedge clk);
    check("midreload_busy", 32'(busy), 1);
    pulse_reload();
    wait_load("midreload");
    compare_result("midreload");
    clear_capture();
    pulse_reload();
    wait_load("reload_done");
    compare_result("reload_done");

    // Reset while strobing index 4.
    good_image();
    clear_capture();
    pulse_reload();
    n = 0;
    while (!(bus.stb && bus.adr == 16'd4) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("midreset_reached_idx4", {31'd0, bus.stb}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_cyc", 32'(bus.cyc), 0);
    check("midreset_stb", 32'(bus.stb), 0);
    check("midreset_adr", 32'(bus.adr), 0);
    check("midreset_status", {28'd0, busy, done, err}, 0);
    check("midreset_ld", {15'd0, ld_valid, ld_addr, ld_data}, 0);
    @(negedge clk);
    clear_capture();
    rst_n = 1'b1;
    wait_load("after_reset");
    check("after_reset_first_adr", 32'(first_adr), 0);
    compare_result("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
